// File: rtl/tri_bus_reader.sv
// tri_bus_reader: receiving end of a shared tri-state bus. Grants the bus to
// one requesting source at a time (round-robin), samples the resolved value,
// and hands it downstream over a valid/ready handshake, acking the source.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[N_SRC]          per-source request
//   oe[N_SRC]           one-hot/zero bufif1 enables, one per source
//   bus[WIDTH]          resolved tri bus value
//   ack[N_SRC]          one-cycle pulse to the source whose word was captured
//   out_valid/out_ready downstream handshake
//   out_data, out_src   captured word and index of the source that drove it
//
// Optional feature: define BUS_SETTLE_EN to add a DRIVE settle cycle, so the
// bus is driven for two cycles before it is sampled.
module tri_bus_reader #(
  parameter int WIDTH = 8,
  parameter int N_SRC = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] oe,
  input  logic [WIDTH-1:0] bus,
  output logic [N_SRC-1:0] ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_src
);

  localparam int unsigned NSRC_U = N_SRC;

`ifdef BUS_SETTLE_EN
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [N_SRC-1:0]   oe_q, oe_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;

  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   cand;

  // Round-robin search starting at ptr_q, wrapping at N_SRC-1 -> 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NSRC_U; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NSRC_U);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    oe_d        = oe_q;
    ack_d       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          g_d  = sel;
          oe_d = N_SRC'(1) << sel;
`ifdef BUS_SETTLE_EN
          state_d = DRIVE;
`else
          state_d = SAMPLE;
`endif
        end
      end
`ifdef BUS_SETTLE_EN
      DRIVE: begin
        state_d = SAMPLE;
      end
`endif
      SAMPLE: begin
        out_data_d  = bus;
        out_src_d   = g_q;
        out_valid_d = 1'b1;
        ack_d       = N_SRC'(1) << g_q;
        oe_d        = '0;
        ptr_d       = (g_q == IDX_W'(N_SRC - 1)) ? '0 : g_q + 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Asynchronous reset drops oe immediately so no source keeps driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      oe_q        <= '0;
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      oe_q        <= oe_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign oe        = oe_q;
  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/tri_bus_reader.md
Name: tri_bus_reader

Overview:
- Receiving end of a shared tri-state data bus. Multiple sources each drive the bus through a bufif1 controlled by an output enable.
- This block owns those enables. It grants the bus to one requesting source at a time, round-robin, and samples the resolved bus value.
- It hands the sampled word downstream with a valid/ready handshake and pulses an ack to the source that was read.
- It sits between the tri-state source drivers and a registered consumer.

Parameters:
- WIDTH, 8, bus and output data width in bits.
- N_SRC, 2, number of tri-state sources on the bus (≥2).
- IDX_W, 1, width of the source index; must equal ceil(log2(N_SRC)).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_SRC  req[i]=1: source i has a word to put on the bus.
- oe  output  N_SRC  one-hot/zero enables; wire oe[i] to source i's bufif1 control.
- bus  input  WIDTH  resolved tri bus value.
- ack  output  N_SRC  one-cycle pulse to source i when its word has been captured.
- out_valid  output  1  out_data/out_src hold a captured word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  captured bus word.
- out_src  output  IDX_W  index of the source that drove out_data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, oe=0, ack=0, out_valid=0, out_data=0, out_src=0, rr pointer ptr=0.
  - oe must fall without waiting for a clock edge, so no source keeps driving.
- All outputs are registered. oe is never multi-hot. oe is 0 in IDLE and HOLD.
- State machine:
  - IDLE: if |req, grant g = first i with req[i]=1, searching ptr, ptr+1, …, wrapping at N_SRC-1→0. Set oe<=onehot(g) and latch g. With BUS_SETTLE_EN go to DRIVE, otherwise go to SAMPLE. If req=0, stay in IDLE.
  - DRIVE: one settle cycle. oe held. Go to SAMPLE.
  - SAMPLE: oe held during the cycle. At the edge:
    - out_data<=bus, out_src<=g, out_valid<=1, ack[g]<=1.
    - oe<=0.
    - ptr<=(g+1) wrapped to 0 at N_SRC.
    - go to HOLD.
  - HOLD: ack returns to 0 after one cycle. out_valid/out_data/out_src stay stable until out_ready=1. On out_valid&&out_ready: out_valid<=0 and go to IDLE.
- Latency, counted from the edge where IDLE sees req:
  - oe is high after edge 0.
  - out_valid=1 after edge 2 with BUS_SETTLE_EN, after edge 1 without.
- Minimum period per word: 4 cycles with BUS_SETTLE_EN, 3 without. The single all-zero-oe IDLE/HOLD gap guarantees bus turnaround between owners.
- Boundary conditions:
  - req dropping after grant does not abort; the transfer completes and is acked. Sources must keep driving while oe is high.
  - If req[g] is still high after ack, it is a new request, served per round-robin.
  - All req high: grants rotate 0,1,…,N_SRC-1,0.
  - out_ready high in the cycle out_valid rises: the handshake completes on the next edge.
  - out_ready is ignored when out_valid=0.
  - A bus value of X/Z is captured as-is; there is no checking.

Optional Feature:
- Macro BUS_SETTLE_EN.
- Defined: the DRIVE state is present. The bus is driven for 2 cycles, and sampling happens at the end of the second cycle, for slow or high-capacitance tri buses.
- Undefined: the DRIVE state is removed. IDLE goes directly to SAMPLE, and the bus is sampled at the end of the first oe-high cycle.
- Ports and handshake are identical either way.

Test Plan (WIDTH=8, N_SRC=2):
- Single transfer: after reset, source 1 drives 8'hA5 and req=2'b10, out_ready=1.
  - Expected: oe=2'b10 for 2 cycles with the macro (1 without).
  - Expected: out_valid=1, out_data=8'hA5, out_src=1, and a one-cycle ack=2'b10.
  - Expected: then oe=0, and ptr=0.
- Round robin: req=2'b11 held, src0=8'h11, src1=8'h22, out_ready=1.
  - Expected: outputs in order 11(src0), 22(src1), 11, 22.
  - Expected: oe never 2'b11, with at least one oe=0 cycle between grants.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - Expected: out_data/out_src stable, no new oe, ack only once.
  - Expected: after out_ready=1, out_valid drops next edge, then the next grant follows.
- Request withdrawn: drop req[0] the cycle after oe=2'b01.
  - Expected: the transfer still completes with ack[0] pulsed and the word captured.
- Async reset mid-transfer: assert rst_n=0 between clock edges during DRIVE/SAMPLE.
  - Expected: oe=0, out_valid=0, ack=0 immediately with no clock edge.
  - Expected: after release, the first grant is to src0 if both request.
- Macro off build: repeat the single-transfer scenario.
  - Expected: out_valid rises 1 edge earlier, and oe is high for exactly 1 cycle.
